// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared types and helpers for the registered sequential ALU.
//   fun_sel_e   : 5-bit operation code (all 32 encodings named)
//   alu_state_e : control FSM states
//   FLAG_*      : bit positions inside FlagsOut
// Optional feature macro: SEQ_ALU_MUL_EN (enables the shift-add multiplier).
package seq_alu_pkg;

  typedef enum logic [4:0] {
    FS_PASS_A = 5'h00, FS_PASS_B, FS_NOT_A, FS_NOT_B,
    FS_ADD,   FS_ADC,    FS_SUB,   FS_AND,
    FS_OR,    FS_XOR,    FS_NAND,  FS_LSL1,
    FS_LSR1,  FS_ASR1,   FS_CSL1,  FS_CSR1,
    FS_SHL,   FS_SHR,    FS_SAR,   FS_MUL,
    FS_RSV14, FS_RSV15,  FS_RSV16, FS_RSV17,
    FS_RSV18, FS_RSV19,  FS_RSV1A, FS_RSV1B,
    FS_RSV1C, FS_RSV1D,  FS_RSV1E, FS_RSV1F
  } fun_sel_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_MUL   = 2'd2
  } alu_state_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_O = 3;

  // Codes that may occupy the ALU for more than one cycle.
  function automatic logic is_multi_cycle(input fun_sel_e fs);
`ifdef SEQ_ALU_MUL_EN
    return fs inside {FS_SHL, FS_SHR, FS_SAR, FS_MUL};
`else
    return fs inside {FS_SHL, FS_SHR, FS_SAR};
`endif
  endfunction

  // Single-cycle codes that update the carry flag (arithmetic and 1-bit shifts/rotates).
  function automatic logic writes_carry(input fun_sel_e fs);
    return fs inside {FS_ADD, FS_ADC, FS_SUB, FS_LSL1, FS_LSR1, FS_ASR1, FS_CSL1, FS_CSR1};
  endfunction

  // Codes that update the overflow flag.
  function automatic logic writes_ovf(input fun_sel_e fs);
    return fs inside {FS_ADD, FS_ADC, FS_SUB};
  endfunction

endpackage

// File: rtl/seq_alu_core.sv
// seq_alu_core: combinational datapath for the single-cycle codes 0x00-0x0F.
//   op  : low four bits of FunSel
//   a,b : operands; cin : carry-in for A+B+C
//   r   : result; c : carry/borrow/shifted-out bit; o : signed overflow
module seq_alu_core
  import seq_alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] r,
  output logic         c,
  output logic         o
);

  logic [W:0] sum;

  always_comb begin
    // NOTE: every output gets a default first so no branch can infer a latch.
    r   = '0;
    c   = 1'b0;
    o   = 1'b0;
    sum = '0;
    case (fun_sel_e'({1'b0, op}))
      FS_PASS_A: r = a;
      FS_PASS_B: r = b;
      FS_NOT_A:  r = ~a;
      FS_NOT_B:  r = ~b;
      FS_ADD, FS_ADC: begin
        sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, (op[0] & cin)};
        r   = sum[W-1:0];
        c   = sum[W];
        o   = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      FS_SUB: begin
        // The extra top bit of the widened difference is the borrow (a < b).
        sum = {1'b0, a} - {1'b0, b};
        r   = sum[W-1:0];
        c   = sum[W];
        o   = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      FS_AND:  r = a & b;
      FS_OR:   r = a | b;
      FS_XOR:  r = a ^ b;
      FS_NAND: r = ~(a & b);
      FS_LSL1: begin r = {a[W-2:0], 1'b0};    c = a[W-1]; end
      FS_LSR1: begin r = {1'b0, a[W-1:1]};    c = a[0];   end
      FS_ASR1: begin r = {a[W-1], a[W-1:1]};  c = a[0];   end
      FS_CSL1: begin r = {a[W-2:0], a[W-1]};  c = a[W-1]; end
      FS_CSR1: begin r = {a[0], a[W-1:1]};    c = a[0];   end
      default: r = a;
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with a Start/Busy/Done handshake.
//   Clock, Reset (synchronous, active high)
//   Start, FunSel[4:0], WF, A, B : request, sampled together while idle
//   ALUOut, FlagsOut[3:0]        : registered result and Z/C/N/O flags
//   Done                         : one-cycle pulse when ALUOut/FlagsOut update
//   Busy                         : high while a variable shift or multiply runs
// Optional feature macro: SEQ_ALU_MUL_EN adds the iterative shift-add multiplier
// (FunSel 0x13); without it 0x13 behaves as a reserved code.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int W   = 32,
  parameter int SHW = $clog2(W)
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         Start,
  input  logic [4:0]   FunSel,
  input  logic         WF,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic [W-1:0] ALUOut,
  output logic         Done,
  output logic         Busy,
  output logic [3:0]   FlagsOut
);

  localparam int CW = $clog2(W + 1);

  alu_state_e   state_q, state_d;
  fun_sel_e     fun_q, fun_d, fs_in;
  logic         wf_q, wf_d;
  logic [W-1:0] a_q, a_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] alu_out_q, alu_out_d;
  logic [3:0]   flags_q, flags_d;
  logic         done_q, done_d;
  logic         busy_q, busy_d;

  logic [W-1:0] core_r;
  logic         core_c, core_o;
  logic [W-1:0] sh_val;
  logic         sh_out;

  assign fs_in = fun_sel_e'(FunSel);

  seq_alu_core #(.W(W)) u_core (
    .op  (FunSel[3:0]),
    .a   (A),
    .b   (B),
    .cin (flags_q[FLAG_C]),
    .r   (core_r),
    .c   (core_c),
    .o   (core_o)
  );

  // One step of the variable shift on the working register.
  always_comb begin
    if (fun_q == FS_SHL) begin
      sh_val = {a_q[W-2:0], 1'b0};
      sh_out = a_q[W-1];
    end else if (fun_q == FS_SHR) begin
      sh_val = {1'b0, a_q[W-1:1]};
      sh_out = a_q[0];
    end else begin
      sh_val = {a_q[W-1], a_q[W-1:1]};
      sh_out = a_q[0];
    end
  end

`ifdef SEQ_ALU_MUL_EN
  // Right-shifting shift-add: {hi_q, b_q} collects the product while b_q's
  // low bit selects whether the multiplicand is added this step.
  logic [W-1:0] b_q, b_d, hi_q, hi_d;
  logic [W:0]   mul_sum;
  logic [W-1:0] mul_hi, mul_lo;
  assign mul_sum = {1'b0, hi_q} + (b_q[0] ? {1'b0, a_q} : {(W+1){1'b0}});
  assign mul_hi  = mul_sum[W:1];
  assign mul_lo  = {mul_sum[0], b_q[W-1:1]};
`endif

  function automatic logic [3:0] zn_flags(input logic [3:0] f, input logic [W-1:0] r);
    logic [3:0] t;
    t         = f;
    t[FLAG_Z] = (r == '0);
    t[FLAG_N] = r[W-1];
    return t;
  endfunction

  always_comb begin
    state_d   = state_q;
    fun_d     = fun_q;
    wf_d      = wf_q;
    a_d       = a_q;
    cnt_d     = cnt_q;
    alu_out_d = alu_out_q;
    flags_d   = flags_q;
    done_d    = 1'b0;
`ifdef SEQ_ALU_MUL_EN
    b_d       = b_q;
    hi_d      = hi_q;
`endif
    case (state_q)
      S_IDLE: if (Start) begin
        fun_d = fs_in;
        wf_d  = WF;
        a_d   = A;
        if (!FunSel[4]) begin
          alu_out_d = core_r;
          done_d    = 1'b1;
          if (WF) begin
            flags_d = zn_flags(flags_q, core_r);
            if (writes_carry(fs_in)) flags_d[FLAG_C] = core_c;
            if (writes_ovf(fs_in))   flags_d[FLAG_O] = core_o;
          end
        end else if (is_multi_cycle(fs_in)) begin
`ifdef SEQ_ALU_MUL_EN
          if (fs_in == FS_MUL) begin
            state_d = S_MUL;
            cnt_d   = CW'(W);
            b_d     = B;
            hi_d    = '0;
          end else
`endif
          if (B[SHW-1:0] == '0) begin
            // Zero-length shift completes at once and leaves carry alone.
            alu_out_d = A;
            done_d    = 1'b1;
            if (WF) flags_d = zn_flags(flags_q, A);
          end else begin
            state_d = S_SHIFT;
            cnt_d   = CW'(B[SHW-1:0]);
          end
        end else begin
          // Reserved code: pass A through, never touch the flags.
          alu_out_d = A;
          done_d    = 1'b1;
        end
      end
      S_SHIFT: begin
        a_d   = sh_val;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d   = S_IDLE;
          alu_out_d = sh_val;
          done_d    = 1'b1;
          if (wf_q) begin
            flags_d         = zn_flags(flags_q, sh_val);
            flags_d[FLAG_C] = sh_out;
          end
        end
      end
`ifdef SEQ_ALU_MUL_EN
      S_MUL: begin
        hi_d  = mul_hi;
        b_d   = mul_lo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d   = S_IDLE;
          alu_out_d = mul_lo;
          done_d    = 1'b1;
          if (wf_q) begin
            flags_d         = zn_flags(flags_q, mul_lo);
            flags_d[FLAG_C] = (mul_hi != '0);
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge Clock) begin
    // NOTE: reset clears the working registers too, so an aborted operation
    // leaves no stale operand or count behind.
    if (Reset) begin
      state_q   <= S_IDLE;
      fun_q     <= FS_PASS_A;
      wf_q      <= 1'b0;
      a_q       <= '0;
      cnt_q     <= '0;
      alu_out_q <= '0;
      flags_q   <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      b_q       <= '0;
      hi_q      <= '0;
`endif
    end else begin
      // NOTE: non-blocking so every flop captures the pre-edge value of its _d.
      state_q   <= state_d;
      fun_q     <= fun_d;
      wf_q      <= wf_d;
      a_q       <= a_d;
      cnt_q     <= cnt_d;
      alu_out_q <= alu_out_d;
      flags_q   <= flags_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
`ifdef SEQ_ALU_MUL_EN
      b_q       <= b_d;
      hi_q      <= hi_d;
`endif
    end
  end

  assign ALUOut   = alu_out_q;
  assign Done     = done_q;
  assign Busy     = busy_q;
  assign FlagsOut = flags_q;

endmodule
